// File: rtl/i2c_line_filter.sv
// Multi-channel run-length glitch filter for slow open-drain pads (I2C SCL/SDA),
// with rise/fall strobes, START/STOP detection on channels 0/1 and a bus-busy flag.
module i2c_line_filter #(
  parameter int                     CHANNELS    = 2,
  parameter int                     MAX_LEN     = 1023,
  parameter int                     SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]    RESET_VAL   = {CHANNELS{1'b1}},
  parameter bit                     I2C_COND    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            inp,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  output logic [CHANNELS-1:0]            out,
  output logic [CHANNELS-1:0]            rise,
  output logic [CHANNELS-1:0]            fall,
  output logic                           start_det,
  output logic                           stop_det,
  output logic                           busy
);

  localparam int LW = $clog2(MAX_LEN+1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [LW-1:0]       thr;
  logic [LW-1:0]       cnt     [CHANNELS];
  logic [LW-1:0]       nxt_cnt [CHANNELS];
  logic [CHANNELS-1:0] nxt_out;
  logic [CHANNELS-1:0] nxt_rise;
  logic [CHANNELS-1:0] nxt_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= inp;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A zero length still needs one differing sample; oversized lengths clamp.
  always_comb begin
    if (cfg_len == '0)
      thr = LW'(1);
    else if (int'(cfg_len) > MAX_LEN)
      thr = LW'(MAX_LEN);
    else
      thr = cfg_len;
  end

  always_comb begin
    nxt_out  = out;
    nxt_rise = '0;
    nxt_fall = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      nxt_cnt[i] = '0;
      if (s[i] != out[i]) begin
        if (({1'b0, cnt[i]} + (LW+1)'(1)) >= {1'b0, thr}) begin
          nxt_out[i]  = ~out[i];
          nxt_rise[i] = s[i];
          nxt_fall[i] = ~s[i];
        end else if (cnt[i] != '1) begin
          nxt_cnt[i] = cnt[i] + LW'(1);
        end else begin
          nxt_cnt[i] = cnt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      out  <= nxt_out;
      rise <= nxt_rise;
      fall <= nxt_fall;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= nxt_cnt[i];
    end
  end

  generate
    if (I2C_COND) begin : g_cond
      // SCL must be high both before and after the SDA edge for a valid condition.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          start_det <= 1'b0;
          stop_det  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          start_det <= nxt_fall[1] & out[0] & nxt_out[0];
          stop_det  <= nxt_rise[1] & out[0] & nxt_out[0];
          if (start_det)
            busy <= 1'b1;
          else if (stop_det)
            busy <= 1'b0;
        end
      end
    end else begin : g_nocond
      assign start_det = 1'b0;
      assign stop_det  = 1'b0;
      assign busy      = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_i2c_line_filter.sv
// Directed self-checking bench for i2c_line_filter: main instance plus a small
// MAX_LEN instance for the length-clamping case.
module tb_i2c_line_filter;

  logic       clk;
  logic       rst_n;
  logic [1:0] inp;
  logic [9:0] cfg_len;
  logic [1:0] out, rise, fall;
  logic       start_det, stop_det, busy;

  logic [1:0] inp_c;
  logic [3:0] cfg_len_c;
  logic [1:0] out_c, rise_c, fall_c;
  logic       start_c, stop_c, busy_c;

  int checks, errors;
  int cycle;
  int nrise [2];
  int nfall [2];
  int rise_at [2];
  int fall_at [2];
  int nstart, nstop, start_at, stop_at;
  int busy_set_at, busy_clr_at;
  int nfall_c, fall_c_at;
  int c0;
  logic prev_busy;

  i2c_line_filter dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .cfg_len(cfg_len),
    .out(out), .rise(rise), .fall(fall),
    .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  i2c_line_filter #(.MAX_LEN(12), .I2C_COND(1'b0)) dut_clamp (
    .clk(clk), .rst_n(rst_n), .inp(inp_c), .cfg_len(cfg_len_c),
    .out(out_c), .rise(rise_c), .fall(fall_c),
    .start_det(start_c), .stop_det(stop_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    for (int ch = 0; ch < 2; ch++) begin
      nrise[ch] = 0; nfall[ch] = 0; rise_at[ch] = -1; fall_at[ch] = -1;
    end
    nstart = 0; nstop = 0; start_at = -1; stop_at = -1;
    busy_set_at = -1; busy_clr_at = -1;
    nfall_c = 0; fall_c_at = -1;
    c0 = cycle;
  endtask

  // Advance one clock and log every strobe seen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    for (int ch = 0; ch < 2; ch++) begin
      if (rise[ch] === 1'b1) begin nrise[ch]++; rise_at[ch] = cycle - c0; end
      if (fall[ch] === 1'b1) begin nfall[ch]++; fall_at[ch] = cycle - c0; end
    end
    if (start_det === 1'b1) begin nstart++; start_at = cycle - c0; end
    if (stop_det === 1'b1) begin nstop++; stop_at = cycle - c0; end
    if (busy === 1'b1 && prev_busy === 1'b0) busy_set_at = cycle - c0;
    if (busy === 1'b0 && prev_busy === 1'b1) busy_clr_at = cycle - c0;
    prev_busy = busy;
    if (fall_c[0] === 1'b1) begin nfall_c++; fall_c_at = cycle - c0; end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input int n);
    inp = v;
    repeat (n) tick();
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; prev_busy = 1'b0;
    rst_n = 1'b0; inp = 2'b11; cfg_len = 10'd8;
    inp_c = 2'b11; cfg_len_c = 4'd15;
    clearCounts();

    // Reset held while the pads toggle.
    applyStimulus(2'b00, 2);
    applyStimulus(2'b10, 2);
    applyStimulus(2'b01, 2);
    checkOutput("reset_out", out, 2'b11);
    checkOutput("reset_strobes", {rise, fall, start_det, stop_det, busy}, 0);
    checkOutput("reset_out_clamp", out_c, 2'b11);
    applyStimulus(2'b11, 2);
    rst_n = 1'b1;
    clearCounts();
    applyStimulus(2'b11, 100);
    checkOutput("idle_strobes", nrise[0] + nrise[1] + nfall[0] + nfall[1] + nstart + nstop, 0);
    checkOutput("idle_out", out, 2'b11);

    // Seven-cycle SDA glitch is rejected with T=8.
    clearCounts();
    applyStimulus(2'b01, 7);
    applyStimulus(2'b11, 20);
    checkOutput("glitch7_nfall", nfall[1], 0);
    checkOutput("glitch7_out", out, 2'b11);

    // Eight-cycle SDA low with SCL high: fall + START at +10, busy next cycle.
    clearCounts();
    applyStimulus(2'b01, 14);
    checkOutput("glitch8_nfall", nfall[1], 1);
    checkOutput("glitch8_fall_at", fall_at[1], 10);
    checkOutput("glitch8_out", out, 2'b01);
    checkOutput("start_count", nstart, 1);
    checkOutput("start_at", start_at, 10);
    checkOutput("busy_set_at", busy_set_at, 11);
    checkOutput("busy_high", busy, 1);

    // SDA rises with SCL high: STOP at +10, busy clears next cycle.
    clearCounts();
    applyStimulus(2'b11, 14);
    checkOutput("stop_count", nstop, 1);
    checkOutput("stop_at", stop_at, 10);
    checkOutput("stop_rise_at", rise_at[1], 10);
    checkOutput("busy_clr_at", busy_clr_at, 11);
    checkOutput("busy_low", busy, 0);

    // Hysteresis with T=5: low 4, high 1, low 5 -> one fall, at +12.
    cfg_len = 10'd5;
    clearCounts();
    applyStimulus(2'b10, 4);
    applyStimulus(2'b11, 1);
    applyStimulus(2'b10, 12);
    checkOutput("hyst_nfall", nfall[0], 1);
    checkOutput("hyst_fall_at", fall_at[0], 12);
    checkOutput("hyst_no_cond", nstart + nstop, 0);
    applyStimulus(2'b11, 10);
    checkOutput("hyst_restore", out, 2'b11);

    // cfg_len=0 behaves as T=1: three-cycle latency.
    cfg_len = 10'd0;
    clearCounts();
    applyStimulus(2'b10, 6);
    checkOutput("len0_fall_at", fall_at[0], 3);
    checkOutput("len0_out", out, 2'b10);
    clearCounts();
    applyStimulus(2'b11, 6);
    checkOutput("len0_rise_at", rise_at[0], 3);

    // Lower T from 20 to 3 after ten differing samples: flip on the next one.
    cfg_len = 10'd20;
    clearCounts();
    applyStimulus(2'b10, 12);
    checkOutput("lower_no_flip_yet", nfall[0], 0);
    cfg_len = 10'd3;
    applyStimulus(2'b10, 5);
    checkOutput("lower_fall_at", fall_at[0], 13);
    checkOutput("lower_nfall", nfall[0], 1);
    cfg_len = 10'd8;
    applyStimulus(2'b11, 20);

    // Oversized length on the MAX_LEN=12 instance clamps to 12: flip at +14.
    clearCounts();
    inp_c = 2'b10;
    repeat (20) tick();
    checkOutput("clamp_nfall", nfall_c, 1);
    checkOutput("clamp_fall_at", fall_c_at, 14);
    checkOutput("clamp_out", out_c, 2'b10);

    // SDA and SCL moving together produce no condition.
    clearCounts();
    applyStimulus(2'b00, 14);
    checkOutput("together_fall_out", out, 2'b00);
    applyStimulus(2'b11, 14);
    checkOutput("together_rise_out", out, 2'b11);
    checkOutput("together_no_cond", nstart + nstop, 0);
    checkOutput("together_busy", busy, 0);

    // Reset in the middle of a transaction with counters mid-run.
    clearCounts();
    applyStimulus(2'b01, 14);
    checkOutput("midrst_busy_before", busy, 1);
    applyStimulus(2'b00, 6);
    rst_n = 1'b0;
    applyStimulus(2'b11, 2);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out", out, 2'b11);
    checkOutput("midrst_strobes", {rise, fall, start_det, stop_det}, 0);
    rst_n = 1'b1;
    clearCounts();
    applyStimulus(2'b11, 30);
    checkOutput("midrst_after_strobes", nrise[0] + nrise[1] + nfall[0] + nfall[1] + nstart + nstop, 0);
    checkOutput("midrst_after_out", out, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
